// File: rtl/post_spike_aer_encoder_pkg.sv
// Shared types and constants for the post-synaptic spike AER encoder.
package post_spike_aer_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKLO = 2'd2
    } aer_state_t;

    localparam int DEF_FIFO_DEPTH = 16;
    localparam int FIFO_PTR_WIDTH = $clog2(DEF_FIFO_DEPTH);
    localparam int DROP_CNT_WIDTH = 8;

    // Saturating increment so the drop counter sticks at all-ones.
    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/post_spike_aer_encoder_if.sv
// Spike-vector input, status and AER output bundle; master = neuron core/AER receiver side, slave = encoder.
interface post_spike_aer_encoder_if
    import post_spike_aer_encoder_pkg::*;
#(
    parameter int POST_NEUR_PARALLEL        = 4,
    parameter int POST_NEUR_WORD_ADDR_WIDTH = 8,
    parameter int POST_NEUR_BYTE_ADDR_WIDTH = 2,
    parameter int AER_WIDTH                 = 12
);
    logic                                                     SPK_VALID;
    logic [POST_NEUR_PARALLEL-1:0]                            SPK_VEC;
    logic [POST_NEUR_WORD_ADDR_WIDTH-POST_NEUR_BYTE_ADDR_WIDTH-1:0] SPK_WORD_ADDR;
    logic                                                     SPK_FLUSH;
    logic                                                     SPK_READY;
    logic                                                     SPK_DROP;
    logic [DROP_CNT_WIDTH-1:0]                                SPK_DROP_CNT;
    logic                                                     FIFO_EMPTY;
    logic                                                     FIFO_FULL;
    logic [AER_WIDTH-1:0]                                     AEROUT_ADDR;
    logic                                                     AEROUT_REQ;
    logic                                                     AEROUT_ACK;

    modport master (
        output SPK_VALID, SPK_VEC, SPK_WORD_ADDR, SPK_FLUSH, AEROUT_ACK,
        input  SPK_READY, SPK_DROP, SPK_DROP_CNT, FIFO_EMPTY, FIFO_FULL, AEROUT_ADDR, AEROUT_REQ
    );

    modport slave (
        input  SPK_VALID, SPK_VEC, SPK_WORD_ADDR, SPK_FLUSH, AEROUT_ACK,
        output SPK_READY, SPK_DROP, SPK_DROP_CNT, FIFO_EMPTY, FIFO_FULL, AEROUT_ADDR, AEROUT_REQ
    );
endinterface

// File: rtl/post_spike_aer_encoder_spike_event_fifo.sv
// Synchronous event FIFO with fall-through head, registered full/empty flags and a clear input.
module spike_event_fifo
    import post_spike_aer_encoder_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int PTR_W = FIFO_PTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic             full_reg, empty_reg;
    logic             do_push, do_pop;

    // A pop never frees space for a push in the same cycle.
    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + 1'b1;
        else if (!do_push && do_pop)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == (PTR_W+1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wdata;
    end

    assign rdata = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;
endmodule

// File: rtl/post_spike_aer_encoder.sv
// Serialises post-neuron spike vectors into flat addresses, queues them and emits them over 4-phase AER.
// Optional build macro SPIKE_DROP_CNT_EN enables the saturating dropped-vector counter.
module post_spike_aer_encoder
    import post_spike_aer_encoder_pkg::*;
#(
    parameter int POST_NEUR_PARALLEL        = 4,
    parameter int POST_NEUR_WORD_ADDR_WIDTH = 8,
    parameter int POST_NEUR_BYTE_ADDR_WIDTH = 2,
    parameter int AER_WIDTH                 = 12,
    parameter int FIFO_DEPTH                = DEF_FIFO_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    post_spike_aer_encoder_if.slave  bus
);
    localparam int BASE_W = POST_NEUR_WORD_ADDR_WIDTH - POST_NEUR_BYTE_ADDR_WIDTH;

    logic [POST_NEUR_PARALLEL-1:0]        mask_reg;
    logic [BASE_W-1:0]                    base_reg;
    logic [POST_NEUR_BYTE_ADDR_WIDTH-1:0] lane;
    logic                                 drop_reg;
    aer_state_t                           state_reg;
    logic [AER_WIDTH-1:0]                 addr_reg;
    logic                                 req_reg;

    logic ready, flush, vec_nz, capture, drop_evt;
    logic scan_push, fifo_pop, fifo_full, fifo_empty;
    logic [AER_WIDTH-1:0] ev_addr, head_addr;

    assign flush    = bus.SPK_FLUSH;
    assign ready    = (mask_reg == '0);
    assign vec_nz   = |bus.SPK_VEC;
    assign capture  = bus.SPK_VALID && !flush && vec_nz && ready;
    assign drop_evt = bus.SPK_VALID && !flush && vec_nz && !ready;

    // Lowest pending lane wins: scan from the top so the last hit is the lowest.
    always_comb begin
        lane = '0;
        for (int i = POST_NEUR_PARALLEL - 1; i >= 0; i--) begin
            if (mask_reg[i]) lane = POST_NEUR_BYTE_ADDR_WIDTH'(i);
        end
    end

    assign ev_addr   = AER_WIDTH'({base_reg, lane});
    assign scan_push = !ready && !fifo_full && !flush;
    assign fifo_pop  = (state_reg == IDLE) && !fifo_empty && !flush;

    always_ff @(posedge CLK) begin
        if (!RST_N || flush) begin
            mask_reg <= '0;
            base_reg <= '0;
            drop_reg <= 1'b0;
        end else begin
            if (capture) begin
                mask_reg <= bus.SPK_VEC;
                base_reg <= bus.SPK_WORD_ADDR;
            end else if (scan_push) begin
                mask_reg <= mask_reg & ~(POST_NEUR_PARALLEL'(1) << lane);
            end
            if (drop_evt) drop_reg <= 1'b1;
        end
    end

`ifdef SPIKE_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_reg;
    always_ff @(posedge CLK) begin
        if (!RST_N || flush)
            drop_cnt_reg <= '0;
        else if (drop_evt)
            drop_cnt_reg <= sat_inc(drop_cnt_reg);
    end
    assign bus.SPK_DROP_CNT = drop_cnt_reg;
`else
    assign bus.SPK_DROP_CNT = '0;
`endif

    spike_event_fifo #(
        .WIDTH (AER_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .PTR_W ($clog2(FIFO_DEPTH))
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .clear (flush),
        .push  (scan_push),
        .pop   (fifo_pop),
        .wdata (ev_addr),
        .rdata (head_addr),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Flush leaves the handshake alone so an in-flight event completes with its latched address.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            req_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (fifo_pop) begin
                    addr_reg  <= head_addr;
                    req_reg   <= 1'b1;
                    state_reg <= REQ;
                end
                REQ: if (bus.AEROUT_ACK) begin
                    req_reg   <= 1'b0;
                    state_reg <= ACKLO;
                end
                ACKLO: if (!bus.AEROUT_ACK) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.SPK_READY   = ready;
    assign bus.SPK_DROP    = drop_reg;
    assign bus.FIFO_EMPTY  = fifo_empty;
    assign bus.FIFO_FULL   = fifo_full;
    assign bus.AEROUT_ADDR = addr_reg;
    assign bus.AEROUT_REQ  = req_reg;
endmodule

// File: tb/tb_post_spike_aer_encoder.sv
// Scoreboard bench: stimulus queues expected AER addresses, a monitor checks each REQ rising edge.
module tb_post_spike_aer_encoder;
    import post_spike_aer_encoder_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   req_rises = 0;
    int   ack_mode = 0;   // 0: ack follows req, 1: held low, 2: held high
    int   exp_q[$];

    post_spike_aer_encoder_if bus ();

    post_spike_aer_encoder dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // AER receiver model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       bus.AEROUT_ACK = bus.AEROUT_REQ;
                1:       bus.AEROUT_ACK = 1'b0;
                default: bus.AEROUT_ACK = 1'b1;
            endcase
        end
    end

    // Monitor: one scoreboard pop per REQ rising edge
    initial begin
        logic prev_req;
        int   e;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.AEROUT_REQ && !prev_req) begin
                req_rises++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: addr=%0d, nothing expected", bus.AEROUT_ADDR);
                end else begin
                    e = exp_q.pop_front();
                    check("aer_addr", int'(bus.AEROUT_ADDR), e);
                end
            end
            prev_req = bus.AEROUT_REQ;
        end
    end

    task automatic send(input logic [3:0] vec, input int word);
        bus.SPK_VEC       = vec;
        bus.SPK_WORD_ADDR = 6'(word);
        bus.SPK_VALID     = 1'b1;
        step();
        bus.SPK_VALID = 1'b0;
        bus.SPK_VEC   = '0;
    endtask

    task automatic wait_ready(input int budget);
        int k = 0;
        while (!bus.SPK_READY && k < budget) begin
            step();
            k++;
        end
        check("wait_ready", int'(bus.SPK_READY), 1);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || bus.AEROUT_REQ || !bus.FIFO_EMPTY || !bus.SPK_READY) && k < budget) begin
            step();
            k++;
        end
        repeat (3) step();
        check("drain_queue", exp_q.size(), 0);
    endtask

    task automatic do_flush();
        bus.SPK_FLUSH = 1'b1;
        step();
        bus.SPK_FLUSH = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        int saved_rises;
        int k;
`ifdef SPIKE_DROP_CNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        rst_n             = 1'b0;
        bus.SPK_VALID     = 1'b0;
        bus.SPK_VEC       = '0;
        bus.SPK_WORD_ADDR = '0;
        bus.SPK_FLUSH     = 1'b0;
        bus.AEROUT_ACK    = 1'b0;
        repeat (3) step();
        check("rst_ready", int'(bus.SPK_READY), 1);
        check("rst_empty", int'(bus.FIFO_EMPTY), 1);
        check("rst_full", int'(bus.FIFO_FULL), 0);
        check("rst_drop", int'(bus.SPK_DROP), 0);
        check("rst_drop_cnt", int'(bus.SPK_DROP_CNT), 0);
        check("rst_req", int'(bus.AEROUT_REQ), 0);
        check("rst_addr", int'(bus.AEROUT_ADDR), 0);
        rst_n = 1'b1;
        step();

        // Two lanes of word 3 -> 13, 15; check the 3-edge latency
        exp_q.push_back(13);
        exp_q.push_back(15);
        send(4'b1010, 3);
        check("lat_e0_req", int'(bus.AEROUT_REQ), 0);
        check("busy_not_ready", int'(bus.SPK_READY), 0);
        step();
        check("lat_e1_req", int'(bus.AEROUT_REQ), 0);
        check("lat_e1_not_empty", int'(bus.FIFO_EMPTY), 0);
        step();
        check("lat_e2_req", int'(bus.AEROUT_REQ), 1);
        wait_drain(100);

        // Back-to-back vectors: the second is dropped
        for (int l = 0; l < 4; l++) exp_q.push_back(l);
        bus.SPK_VEC = 4'b1111; bus.SPK_WORD_ADDR = 6'd0; bus.SPK_VALID = 1'b1;
        step();
        bus.SPK_VEC = 4'b0001; bus.SPK_WORD_ADDR = 6'd7;
        step();
        bus.SPK_VALID = 1'b0; bus.SPK_VEC = '0;
        check("drop_set", int'(bus.SPK_DROP), 1);
        check("drop_cnt", int'(bus.SPK_DROP_CNT), exp_cnt);
        wait_drain(100);
        check("drop_sticky", int'(bus.SPK_DROP), 1);
        do_flush();
        check("flush_clears_drop", int'(bus.SPK_DROP), 0);
        check("flush_clears_cnt", int'(bus.SPK_DROP_CNT), 0);

        // ACK held low: 20 events overflow the FIFO, scanner stalls
        ack_mode = 1;
        for (int v = 0; v < 5; v++) begin
            for (int l = 0; l < 4; l++) exp_q.push_back((8 + v) * 4 + l);
            wait_ready(20);
            send(4'b1111, 8 + v);
        end
        repeat (30) step();
        check("stall_full", int'(bus.FIFO_FULL), 1);
        check("stall_not_ready", int'(bus.SPK_READY), 0);
        check("stall_no_drop", int'(bus.SPK_DROP), 0);
        // A zero vector while busy changes nothing
        send(4'b0000, 1);
        step();
        check("zero_vec_no_drop", int'(bus.SPK_DROP), 0);
        check("zero_vec_cnt", int'(bus.SPK_DROP_CNT), 0);
        check("zero_vec_not_ready", int'(bus.SPK_READY), 0);
        check("zero_vec_full", int'(bus.FIFO_FULL), 1);
        ack_mode = 0;
        wait_drain(600);
        check("drain_empty", int'(bus.FIFO_EMPTY), 1);

        // Flush while REQ is up with further entries queued
        ack_mode = 1;
        for (int l = 0; l < 4; l++) exp_q.push_back(4 + l);
        bus.SPK_VEC = 4'b1111; bus.SPK_WORD_ADDR = 6'd1; bus.SPK_VALID = 1'b1;
        step();
        bus.SPK_VEC = 4'b0011; bus.SPK_WORD_ADDR = 6'd2;
        step();
        bus.SPK_VALID = 1'b0; bus.SPK_VEC = '0;
        check("pre_flush_drop", int'(bus.SPK_DROP), 1);
        wait_ready(20);
        exp_q.push_back(8);
        exp_q.push_back(9);
        send(4'b0011, 2);
        repeat (6) step();
        check("pre_flush_req", int'(bus.AEROUT_REQ), 1);
        check("pre_flush_not_empty", int'(bus.FIFO_EMPTY), 0);
        exp_q.delete();
        saved_rises = req_rises;
        do_flush();
        check("flush_empty", int'(bus.FIFO_EMPTY), 1);
        check("flush_drop", int'(bus.SPK_DROP), 0);
        check("flush_ready", int'(bus.SPK_READY), 1);
        check("flush_req_kept", int'(bus.AEROUT_REQ), 1);
        check("flush_addr_kept", int'(bus.AEROUT_ADDR), 4);
        ack_mode = 0;
        k = 0;
        while (bus.AEROUT_REQ && k < 10) begin
            step();
            k++;
        end
        check("flush_hs_done", int'(bus.AEROUT_REQ), 0);
        check("flush_addr_hold", int'(bus.AEROUT_ADDR), 4);
        repeat (20) step();
        check("no_req_after_flush", req_rises, saved_rises);

        // Reset in the middle of ACKLO
        ack_mode = 2;
        for (int l = 0; l < 4; l++) exp_q.push_back(20 + l);
        send(4'b1111, 5);
        repeat (6) step();
        check("in_acklo", int'(dut.state_reg), int'(ACKLO));
        rst_n = 1'b0;
        step();
        check("rst_hs_req", int'(bus.AEROUT_REQ), 0);
        check("rst_hs_state", int'(dut.state_reg), int'(IDLE));
        check("rst_hs_empty", int'(bus.FIFO_EMPTY), 1);
        check("rst_hs_ready", int'(bus.SPK_READY), 1);
        check("rst_hs_addr", int'(bus.AEROUT_ADDR), 0);
        exp_q.delete();
        ack_mode = 0;
        rst_n = 1'b1;
        repeat (5) step();
        check("post_rst_idle_req", int'(bus.AEROUT_REQ), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
